branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 108 ++++++++++
 tb/tb_branch_resolve.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// In-order queue of predicted branches; each resolved outcome yields a one-cycle
// packet {mispredict, correct next PC}, and a mispredict flushes the queue.
module branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_pred_valid,
  output logic                       o_pred_ready,
  input  logic [31:0]                i_pred_pc,
  input  logic                       i_pred_taken,
  input  logic [31:0]                i_pred_target,
  input  logic                       i_res_valid,
  output logic                       o_res_ready,
  input  logic                       i_res_taken,
  input  logic [31:0]                i_res_target,
  output logic                       o_fire,
  output logic [32:0]                o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc_mem  [DEPTH];
  logic             tkn_mem [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];

  logic             push, pop, push_keep;
  logic             mis_p0;
  logic [31:0]      npc_p0;
  logic             vld_p1;
  logic [32:0]      data_p1;

  function automatic logic mispredict(input logic pt, input logic [31:0] ptg,
                                      input logic rt, input logic [31:0] rtg);
    return (pt != rt) || (rt && (ptg != rtg));
  endfunction

  // Not-taken falls through to pc+4; the sum wraps at 32 bits.
  function automatic logic [31:0] next_pc(input logic [31:0] ppc, input logic rt,
                                          input logic [31:0] rtg);
    return rt ? rtg : ppc + 32'd4;
  endfunction

  assign o_pred_ready = !rst && (state == RUN) && (count < CNT_W'(DEPTH));
  assign o_res_ready  = !rst && (state == RUN) && (count != '0);
  assign push         = i_pred_valid && o_pred_ready;
  assign pop          = i_res_valid && o_res_ready;

  // Stage p0: evaluate the oldest entry against the offered outcome
  assign mis_p0    = mispredict(tkn_mem[rd_ptr], tgt_mem[rd_ptr], i_res_taken, i_res_target);
  assign npc_p0    = next_pc(pc_mem[rd_ptr], i_res_taken, i_res_target);
  assign push_keep = push && !(pop && mis_p0);

  always_ff @(posedge clk) begin
    if (push_keep) begin
      pc_mem[wr_ptr]  <= i_pred_pc;
      tkn_mem[wr_ptr] <= i_pred_taken;
      tgt_mem[wr_ptr] <= i_pred_target;
    end
  end

  // Stage p1: registered resolution packet and queue bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) data_p1 <= {mis_p0, npc_p0};
      case (state)
        RUN: begin
          if (pop && mis_p0) begin
            state  <= FLUSH;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end else begin
            if (push_keep) wr_ptr <= wr_ptr + PW'(1);
            if (pop)       rd_ptr <= rd_ptr + PW'(1);
            case ({push_keep, pop})
              2'b10:   count <= count + CNT_W'(1);
              2'b01:   count <= count - CNT_W'(1);
              default: count <= count;
            endcase
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign o_fire  = vld_p1;
  assign o_data  = data_p1;
  assign o_count = count;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomised and directed bench for branch_resolve: a queue-based reference model
// predicts readies/occupancy each cycle and feeds expected packets to a monitor.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pred_valid, o_pred_ready, i_pred_taken;
  logic [31:0] i_pred_pc, i_pred_target;
  logic        i_res_valid, o_res_ready, i_res_taken;
  logic [31:0] i_res_target;
  logic        o_fire;
  logic [32:0] o_data;
  logic [2:0]  o_count;

  branch_resolve #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_pred_valid(i_pred_valid), .o_pred_ready(o_pred_ready),
    .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .i_res_valid(i_res_valid), .o_res_ready(o_res_ready),
    .i_res_taken(i_res_taken), .i_res_target(i_res_target),
    .o_fire(o_fire), .o_data(o_data), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [32:0] sb[$];
  bit          m_flush;
  bit          mon_en;
  bit          rst_seen;
  logic [32:0] mon_last;
  int          tests;
  int          fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: packets pop from the scoreboard; between strobes o_data must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        mon_last = '0;
        rst_seen = 0;
      end
      if (o_fire === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_fire", 64'(o_fire), 64'd0);
        end else begin
          mon_last = sb.pop_front();
          check("packet", 64'(o_data), 64'(mon_last));
        end
      end else begin
        check("fire_low", 64'(o_fire), 64'd0);
        check("data_hold", 64'(o_data), 64'(mon_last));
      end
    end
  end

  // One cycle: drive at negedge, compare readies/occupancy, advance the model.
  task automatic cycle(input bit r, input bit pv, input logic [31:0] pc, input bit pt,
                       input logic [31:0] ptg, input bit rv, input bit rt,
                       input logic [31:0] rtg);
    bit          pr, rr, mis;
    ent_t        e;
    logic [31:0] cp;
    @(negedge clk);
    rst = r; i_pred_valid = pv; i_pred_pc = pc; i_pred_taken = pt; i_pred_target = ptg;
    i_res_valid = rv; i_res_taken = rt; i_res_target = rtg;
    #1;
    pr = !r && !m_flush && (mq.size() < 4);
    rr = !r && !m_flush && (mq.size() > 0);
    if (mon_en) begin
      check("pred_ready", 64'(o_pred_ready), 64'(pr));
      check("res_ready",  64'(o_res_ready),  64'(rr));
      check("count",      64'(o_count),      64'(mq.size()));
    end
    if (r) begin
      mq.delete();
      m_flush  = 0;
      rst_seen = 1;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      mis = 0;
      if (rv && rr) begin
        e   = mq.pop_front();
        mis = (e.taken != rt) || (rt && e.tgt != rtg);
        cp  = rt ? rtg : e.pc + 32'd4;
        sb.push_back({mis, cp});
        if (mis) begin
          mq.delete();
          m_flush = 1;
        end
      end
      if (pv && pr && !mis) mq.push_back('{pc: pc, taken: pt, tgt: ptg});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tests = 0; fails = 0; mon_en = 0; rst_seen = 0; m_flush = 0; mon_last = '0;
    rst = 1; i_pred_valid = 0; i_pred_pc = 0; i_pred_taken = 0; i_pred_target = 0;
    i_res_valid = 0; i_res_taken = 0; i_res_target = 0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1;
    cycle(1, 1, 32'h40, 1, 32'h80, 1, 1, 32'h80);
    check("reset_data", 64'(o_data), 64'd0);
    check("reset_fire", 64'(o_fire), 64'd0);

    // Correct taken prediction
    cycle(0, 1, 32'h100, 1, 32'h200, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h200);
    idle(2);
    // Direction mispredict with a second entry queued, then flush
    cycle(0, 1, 32'h100, 1, 32'h200, 0, 0, 0);
    cycle(0, 1, 32'h204, 0, 32'h0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h0);
    idle(3);
    // Fill to capacity, extra push ignored, one correct pop frees a slot
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h1000 + 32'(i * 8), 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h2000, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // PC wrap on fall-through
    cycle(0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // Push while the oldest mispredicts: the push is discarded
    cycle(0, 1, 32'h300, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h500, 1, 32'h600, 1, 1, 32'h700);
    idle(3);
    // Reset right after a mispredicting pop
    cycle(0, 1, 32'h800, 1, 32'h900, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'hA00);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_after_mis_data", 64'(o_data), 64'd0);
    check("rst_after_mis_fire", 64'(o_fire), 64'd0);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pcs, tgs;
      pcs = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'(($urandom_range(0, 63)) * 4);
      tgs = 32'h200 + 32'($urandom_range(0, 1) * 32'h100);
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, pcs,
            1'($urandom_range(0, 1)), tgs, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 3) != 0) ? mq.size() > 0 && mq[0].taken : 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? tgs : 32'h200);
    end
    idle(3);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
